// File: rtl/me_pkg.sv
// me_pkg: shared state encoding and width helpers for the motion-estimation search
package me_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic int win_w(int blk, int vec_w);
    return blk + (1 << vec_w) - 1;
  endfunction
  function automatic int cur_aw(int blk);
    return $clog2(blk * blk);
  endfunction
  function automatic int ref_aw(int blk, int vec_w);
    return $clog2(win_w(blk, vec_w) * win_w(blk, vec_w));
  endfunction
  function automatic int n_reads(int blk, int vec_w);
    return (1 << (2 * vec_w)) * blk * blk;
  endfunction
  function automatic int acc_w(int blk);
    return 8 + 2 * $clog2(blk);
  endfunction
  function automatic int vec_off(int vec_w);
    return 1 << (vec_w - 1);
  endfunction
endpackage

// File: rtl/me_sad_accum.sv
// me_sad_accum: abs-diff accumulation, best-candidate tracking and saturated result
module me_sad_accum import me_pkg::*; #(
  parameter int BLK = 16,
  parameter int VEC_W = 4,
  parameter int DIST_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 v,
  input  logic                 first_pix,
  input  logic                 last_pix,
  input  logic                 first_cand,
  input  logic                 commit,
  input  logic [2*VEC_W-1:0]   idx,
  input  logic [7:0]           cur_data,
  input  logic [7:0]           ref_data,
  output logic [DIST_W-1:0]    distance,
  output logic [VEC_W-1:0]     vec_x,
  output logic [VEC_W-1:0]     vec_y
);
  localparam int AW = acc_w(BLK);
  localparam logic [VEC_W-1:0] OFF = VEC_W'(vec_off(VEC_W));
  logic [AW-1:0] acc_q, acc_d, best_q, best_d, sad;
  logic [2*VEC_W-1:0] bidx_q, bidx_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic [VEC_W-1:0] vx_q, vx_d, vy_q, vy_d;
  logic [7:0] ad;
  logic take;
  // Candidate SAD, strict-less best update; results latch from the updated best so the final candidate counts
  always_comb begin
    ad = cur_data > ref_data ? cur_data - ref_data : ref_data - cur_data;
    sad = first_pix ? AW'(ad) : acc_q + AW'(ad);
    acc_d = v ? sad : acc_q;
    take = v && last_pix && (first_cand || sad < best_q);
    best_d = take ? sad : best_q;
    bidx_d = take ? idx : bidx_q;
    dist_d = commit ? ((best_d >> DIST_W) != '0 ? '1 : DIST_W'(best_d)) : dist_q;
    vy_d = commit ? bidx_d[2*VEC_W-1:VEC_W] ^ OFF : vy_q;
    vx_d = commit ? bidx_d[VEC_W-1:0] ^ OFF : vx_q;
  end
  // Accumulator, best and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      best_q <= '0;
      bidx_q <= '0;
      dist_q <= '0;
      vx_q <= '0;
      vy_q <= '0;
    end else begin
      acc_q <= acc_d;
      best_q <= best_d;
      bidx_q <= bidx_d;
      dist_q <= dist_d;
      vx_q <= vx_d;
      vy_q <= vy_d;
    end
  end
  assign distance = dist_q;
  assign vec_x = vx_q;
  assign vec_y = vy_q;
endmodule

// File: rtl/me_search_ctrl.sv
// me_search_ctrl: full-search motion-estimation scan FSM and address generator
module me_search_ctrl import me_pkg::*; #(
  parameter int BLK = 16,
  parameter int VEC_W = 4,
  parameter int DIST_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          trigger,
  output logic [cur_aw(BLK)-1:0]        cur_addr,
  input  logic [7:0]                    cur_data,
  output logic [ref_aw(BLK, VEC_W)-1:0] ref_addr,
  input  logic [7:0]                    ref_data,
  output logic                          rd_en,
  output logic                          busy,
  output logic                          done,
  output logic [DIST_W-1:0]             distance,
  output logic [VEC_W-1:0]              vectorX,
  output logic [VEC_W-1:0]              vectorY
);
  localparam int LB = $clog2(BLK);
  localparam int CW = 2 * VEC_W + 2 * LB;
  localparam int W = win_w(BLK, VEC_W);
  localparam int RAW = ref_aw(BLK, VEC_W);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] vy, vx;
  logic [LB-1:0] r, c;
  logic v1_q, v1_d, fp1_q, fp1_d, lp1_q, lp1_d, fc1_q, fc1_d;
  logic [2*VEC_W-1:0] idx1_q, idx1_d;
  // vy/vx are held as offset indices 0..RANGE-1, so one flat counter walks vy, vx, r, c in scan order
  assign {vy, vx, r, c} = cnt_q;
  assign cur_addr = {r, c};
  assign ref_addr = RAW'((int'(vy) + int'(r)) * W + int'(vx) + int'(c));
  // Next state, strobes, scan counter and stage-1 tags
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = trigger ? RUN : IDLE;
      RUN: state_d = &cnt_q ? DRAIN : RUN;
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
    rd_en = state_q == RUN;
    busy = rd_en || state_q == DRAIN;
    done = state_q == DONE;
    cnt_d = rd_en ? cnt_q + CW'(1) : cnt_q;
    v1_d = rd_en;
    fp1_d = {r, c} == '0;
    lp1_d = &{r, c};
    fc1_d = {vy, vx} == '0;
    idx1_d = {vy, vx};
  end
  // State, counter and tag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      v1_q <= 1'b0;
      fp1_q <= 1'b0;
      lp1_q <= 1'b0;
      fc1_q <= 1'b0;
      idx1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      v1_q <= v1_d;
      fp1_q <= fp1_d;
      lp1_q <= lp1_d;
      fc1_q <= fc1_d;
      idx1_q <= idx1_d;
    end
  end
  me_sad_accum #(.BLK(BLK), .VEC_W(VEC_W), .DIST_W(DIST_W)) u_sad (
    .clk(clk),
    .reset(reset),
    .v(v1_q),
    .first_pix(fp1_q),
    .last_pix(lp1_q),
    .first_cand(fc1_q),
    .commit(state_q == DRAIN),
    .idx(idx1_q),
    .cur_data(cur_data),
    .ref_data(ref_data),
    .distance(distance),
    .vec_x(vectorX),
    .vec_y(vectorY)
  );
endmodule

// File: tb/tb_me_search_ctrl.sv
// tb_me_search_ctrl: randomized scenarios checked against a brute-force full-search model
module tb_me_search_ctrl;
  localparam int BLK = 4, VEC_W = 4, DIST_W = 8, W = 19, N = 4096;
  logic clk = 0, reset = 1, trigger = 0;
  logic [3:0] cur_addr;
  logic [8:0] ref_addr;
  logic [7:0] cur_data, ref_data;
  logic rd_en, busy, done;
  logic [7:0] distance;
  logic [3:0] vectorX, vectorY;
  logic [7:0] cur_mem [16];
  logic [7:0] ref_mem [W*W];
  int errors = 0, checks = 0;
  int cyc, rd_cnt, done_cnt, last_ref;
  int ref_log [16];
  int cur_log [16];
  logic busy_at_done;
  logic [7:0] d_dist, e_dist;
  logic [3:0] d_vx, d_vy, e_vx, e_vy;

  me_search_ctrl #(.BLK(BLK), .VEC_W(VEC_W), .DIST_W(DIST_W)) dut (
    .clk(clk), .reset(reset), .trigger(trigger),
    .cur_addr(cur_addr), .cur_data(cur_data),
    .ref_addr(ref_addr), .ref_data(ref_data),
    .rd_en(rd_en), .busy(busy), .done(done),
    .distance(distance), .vectorX(vectorX), .vectorY(vectorY)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data one cycle after the address
  always @(posedge clk) begin
    cur_data <= cur_mem[cur_addr];
    ref_data <= ref_mem[ref_addr];
  end

  // Exhaustive search straight from the definition: first strictly-smaller SAD wins
  task automatic model();
    int best = -1;
    int bx = 0, by = 0;
    for (int vy = -8; vy < 8; vy++)
      for (int vx = -8; vx < 8; vx++) begin
        int s = 0;
        for (int r = 0; r < BLK; r++)
          for (int c = 0; c < BLK; c++) begin
            int d = int'(cur_mem[r*BLK+c]) - int'(ref_mem[(vy+8+r)*W + vx+8+c]);
            s += d < 0 ? -d : d;
          end
        if (best < 0 || s < best) begin
          best = s; bx = vx; by = vy;
        end
      end
    e_dist = best > 255 ? 8'hFF : 8'(best);
    e_vx = 4'(bx);
    e_vy = 4'(by);
  endtask

  task automatic fill_embedded();
    for (int i = 0; i < 16; i++) cur_mem[i] = 8'($urandom_range(0, 127));
    for (int i = 0; i < W*W; i++) ref_mem[i] = 8'($urandom_range(128, 255));
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++) ref_mem[(-2+8+r)*W + 3+8+c] = cur_mem[r*BLK+c];
  endtask

  task automatic fill_const(input logic [7:0] cv, input logic [7:0] rv);
    for (int i = 0; i < 16; i++) cur_mem[i] = cv;
    for (int i = 0; i < W*W; i++) ref_mem[i] = rv;
  endtask

  // Trigger one search and record what the DUT does for a bounded window; poke pulses trigger in RUN and DRAIN
  task automatic run_search(input bit poke);
    cyc = -1; rd_cnt = 0; done_cnt = 0; last_ref = -1; busy_at_done = 1'b1;
    @(negedge clk) trigger = 1;
    @(posedge clk);
    #1 trigger = 0;
    for (int n = 0; n < N + 8; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      trigger = poke && (n == 5 || n == 2000 || n == N);
      if (rd_en) begin
        if (rd_cnt < 16) begin
          ref_log[rd_cnt] = int'(ref_addr);
          cur_log[rd_cnt] = int'(cur_addr);
        end
        last_ref = int'(ref_addr);
        rd_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (cyc < 0) begin
          cyc = n + 1;
          busy_at_done = busy;
          d_dist = distance; d_vx = vectorX; d_vy = vectorY;
        end
      end
    end
    trigger = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, rd_en, cur_addr, ref_addr, distance, vectorX, vectorY} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {busy, done, rd_en, cur_addr, ref_addr, distance, vectorX, vectorY});
    end
    @(negedge clk) reset = 0;
  endtask

  task automatic test_embedded();
    fill_embedded();
    model();
    run_search(0);
    checks++;
    if (cyc !== N + 2) begin errors++; $display("FAIL embed_latency: got %0d want %0d", cyc, N + 2); end
    checks++;
    if (d_dist !== e_dist) begin errors++; $display("FAIL embed_dist: got %h want %h", d_dist, e_dist); end
    checks++;
    if ({d_vx, d_vy} !== {e_vx, e_vy}) begin errors++; $display("FAIL embed_vec: got %h/%h want %h/%h", d_vx, d_vy, e_vx, e_vy); end
    checks++;
    if ({distance, vectorX, vectorY} !== {e_dist, e_vx, e_vy}) begin
      errors++; $display("FAIL embed_hold: got %h %h %h want %h %h %h", distance, vectorX, vectorY, e_dist, e_vx, e_vy);
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL embed_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_all_zero();
    fill_const(8'h00, 8'h00);
    model();
    run_search(0);
    checks++;
    if ({d_dist, d_vx, d_vy} !== {e_dist, e_vx, e_vy} || cyc !== N + 2) begin
      errors++; $display("FAIL zero_tie: got %h %h %h @%0d want %h %h %h @%0d", d_dist, d_vx, d_vy, cyc, e_dist, e_vx, e_vy, N + 2);
    end
  endtask

  task automatic test_saturation();
    fill_const(8'hFF, 8'h00);
    model();
    run_search(0);
    checks++;
    if ({d_dist, d_vx, d_vy} !== {e_dist, e_vx, e_vy} || cyc !== N + 2) begin
      errors++; $display("FAIL saturation: got %h %h %h @%0d want %h %h %h @%0d", d_dist, d_vx, d_vy, cyc, e_dist, e_vx, e_vy, N + 2);
    end
  endtask

  task automatic test_addr_seq();
    for (int i = 0; i < 16; i++) cur_mem[i] = 8'($urandom);
    for (int i = 0; i < W*W; i++) ref_mem[i] = 8'($urandom);
    model();
    run_search(0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cur_log[i] !== i) begin errors++; $display("FAIL cur_addr[%0d]: got %0d want %0d", i, cur_log[i], i); end
      checks++;
      if (ref_log[i] !== (i / BLK) * W + i % BLK) begin
        errors++; $display("FAIL ref_addr[%0d]: got %0d want %0d", i, ref_log[i], (i / BLK) * W + i % BLK);
      end
    end
    checks++;
    if (last_ref !== 360) begin errors++; $display("FAIL last_ref_addr: got %0d want 360", last_ref); end
    checks++;
    if (rd_cnt !== N) begin errors++; $display("FAIL rd_en_cycles: got %0d want %0d", rd_cnt, N); end
    checks++;
    if ({d_dist, d_vx, d_vy} !== {e_dist, e_vx, e_vy}) begin
      errors++; $display("FAIL random_result: got %h %h %h want %h %h %h", d_dist, d_vx, d_vy, e_dist, e_vx, e_vy);
    end
  endtask

  task automatic test_back_to_back();
    fill_embedded();
    model();
    run_search(1);
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL busy_trig_done_count: got %0d want 1", done_cnt); end
    checks++;
    if (cyc !== N + 2) begin errors++; $display("FAIL busy_trig_latency: got %0d want %0d", cyc, N + 2); end
    checks++;
    if (busy_at_done !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b want 0", busy_at_done); end
    checks++;
    if (rd_cnt !== N) begin errors++; $display("FAIL busy_trig_rd_en: got %0d want %0d", rd_cnt, N); end
    checks++;
    if ({d_dist, d_vx, d_vy} !== {e_dist, e_vx, e_vy}) begin
      errors++; $display("FAIL busy_trig_result: got %h %h %h want %h %h %h", d_dist, d_vx, d_vy, e_dist, e_vx, e_vy);
    end
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    fill_embedded();
    model();
    @(negedge clk) trigger = 1;
    @(posedge clk);
    #1 trigger = 0;
    repeat (999) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, rd_en, cur_addr, ref_addr, distance, vectorX, vectorY} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h want 0", {busy, done, rd_en, cur_addr, ref_addr, distance, vectorX, vectorY});
    end
    reset = 0;
    for (int i = 0; i < N + 10; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", dn); end
    checks++;
    if ({distance, vectorX, vectorY} !== '0) begin errors++; $display("FAIL abort_outputs: got %h want 0", {distance, vectorX, vectorY}); end
    run_search(0);
    checks++;
    if (cyc !== N + 2 || {d_dist, d_vx, d_vy} !== {e_dist, e_vx, e_vy}) begin
      errors++; $display("FAIL rerun_after_abort: got %h %h %h @%0d want %h %h %h @%0d", d_dist, d_vx, d_vy, cyc, e_dist, e_vx, e_vy, N + 2);
    end
  endtask

  initial begin
    test_reset();
    test_embedded();
    test_all_zero();
    test_saturation();
    test_addr_seq();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
